// File: rtl/psum_sched.sv
// Partial-sum buffer sequencer: zero-init, multi-pass accumulation with ping-pong
// bank parity, pipeline-drain gaps between passes, and a final read-out/zero-back sweep.
module psum_sched #(
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 46,
   parameter int PASS_WIDTH = 8,
   parameter int PIPE_LAT   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] cfg_row_len,
   input  logic [PASS_WIDTH-1:0] cfg_num_pass,
   input  logic                  abort,
   input  logic                  pe_valid,
   output logic                  pe_ready,
   output logic                  p_init,
   output logic                  p_valid_data,
   output logic                  p_write_zero,
   output logic                  odd_cnt,
   output logic [PASS_WIDTH-1:0] pass_idx,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err
);
   localparam int GAP_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [GAP_W-1:0]      GAP_LAST = GAP_W'(PIPE_LAT - 1);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);
   localparam logic [PASS_WIDTH-1:0] ONE_P    = PASS_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_STREAM,
      S_GAP,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] row_len;
   logic [ADDR_WIDTH-1:0] elem_cnt;
   logic [PASS_WIDTH-1:0] num_pass;
   logic [GAP_W-1:0]      gap_cnt;
   logic                  last_elem;
   logic                  last_pass;
   logic                  cfg_bad;

   assign last_elem = (elem_cnt == row_len - ONE_A);
   assign last_pass = (pass_idx == num_pass - ONE_P);
   assign cfg_bad   = (cfg_row_len == '0) || (cfg_row_len > DEPTH_A) || (cfg_num_pass == '0);

   // Strobes decode the registered state; abort masks them in the same cycle it arrives.
   assign busy         = (state != S_IDLE);
   assign done         = (state == S_DONE);
   assign p_init       = (state == S_INIT) && !abort;
   assign pe_ready     = (state == S_STREAM) && !abort;
   assign p_valid_data = pe_valid && pe_ready;
   assign p_write_zero = (state == S_DRAIN) && !abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         row_len  <= '0;
         num_pass <= '0;
         elem_cnt <= '0;
         gap_cnt  <= '0;
         pass_idx <= '0;
         odd_cnt  <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         cfg_err <= 1'b0;
         if (abort && state != S_IDLE) begin
            state    <= S_IDLE;
            elem_cnt <= '0;
            pass_idx <= '0;
            odd_cnt  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     row_len  <= cfg_row_len;
                     num_pass <= cfg_num_pass;
                     if (cfg_bad) begin
                        cfg_err <= 1'b1;
                     end else begin
                        elem_cnt <= '0;
                        pass_idx <= '0;
                        odd_cnt  <= 1'b0;
                        state    <= S_INIT;
                     end
                  end
               end
               S_INIT: begin
                  if (last_elem) begin
                     elem_cnt <= '0;
                     state    <= S_STREAM;
                  end else begin
                     elem_cnt <= elem_cnt + ONE_A;
                  end
               end
               S_STREAM: begin
                  if (pe_valid) begin
                     if (last_elem) begin
                        elem_cnt <= '0;
                        gap_cnt  <= '0;
                        state    <= S_GAP;
                     end else begin
                        elem_cnt <= elem_cnt + ONE_A;
                     end
                  end
               end
               // Idle cycles let the adder pipeline retire before the bank parity flips.
               S_GAP: begin
                  if (gap_cnt == GAP_LAST) begin
                     elem_cnt <= '0;
                     if (last_pass) begin
                        state <= S_DRAIN;
                     end else begin
                        pass_idx <= pass_idx + ONE_P;
                        odd_cnt  <= !odd_cnt;
                        state    <= S_STREAM;
                     end
                  end else begin
                     gap_cnt <= gap_cnt + 1'b1;
                  end
               end
               S_DRAIN: begin
                  if (last_elem) begin
                     elem_cnt <= '0;
                     state    <= S_DONE;
                  end else begin
                     elem_cnt <= elem_cnt + ONE_A;
                  end
               end
               S_DONE: begin
                  state <= S_IDLE;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_psum_sched.sv
// Directed self-checking bench for psum_sched: basic, multi-pass, stall,
// illegal configuration, abort and asynchronous reset scenarios.
module tb_psum_sched;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       pe_valid = 1'b0;
   logic [7:0] cfg_row_len = '0;
   logic [7:0] cfg_num_pass = '0;
   logic       pe_ready, p_init, p_valid_data, p_write_zero, odd_cnt, busy, done, cfg_err;
   logic [7:0] pass_idx;

   int tests = 0;
   int fails = 0;

   int n_init, n_valid, n_wz, n_idle, n_bad, n_err, n_done, wz_odd0;
   int first_init, first_ready, last_beat, first_idle, done_cyc, busy_after;
   int q_odd[$];
   int q_pass[$];

   logic [7:0] ill_rl [3];
   logic [7:0] ill_np [3];

   psum_sched #(
      .ADDR_WIDTH(8),
      .DEPTH(46),
      .PASS_WIDTH(8),
      .PIPE_LAT(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .cfg_row_len(cfg_row_len),
      .cfg_num_pass(cfg_num_pass),
      .abort(abort),
      .pe_valid(pe_valid),
      .pe_ready(pe_ready),
      .p_init(p_init),
      .p_valid_data(p_valid_data),
      .p_write_zero(p_write_zero),
      .odd_cnt(odd_cnt),
      .pass_idx(pass_idx),
      .busy(busy),
      .done(done),
      .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // At most one buffer strobe may be active in any cycle.
   always @(negedge clk) begin
      #2;
      if (!rst) checkOutput("strobe_excl", 32'($onehot0({p_init, p_valid_data, p_write_zero})), 1);
   end

   assert property (@(posedge clk) disable iff (rst) $onehot0({p_init, p_valid_data, p_write_zero}))
      else $error("[TB] strobe exclusivity violated");

   // Runs one tile from a start pulse to one cycle past done, collecting strobe statistics.
   task automatic applyStimulus(input logic [7:0] rl, input logic [7:0] np,
                                input logic [15:0] pat, input int pat_len);
      int   cyc, pidx, after;
      logic seen_done, prev_ready;
      n_init = 0; n_valid = 0; n_wz = 0; n_idle = 0; n_bad = 0; n_err = 0; n_done = 0; wz_odd0 = 0;
      first_init = -1; first_ready = -1; last_beat = -1; first_idle = -1; done_cyc = -1; busy_after = -1;
      q_odd.delete();
      q_pass.delete();
      pidx = 0; after = 0; seen_done = 1'b0; prev_ready = 1'b0;
      @(negedge clk);
      start = 1'b1; cfg_row_len = rl; cfg_num_pass = np; pe_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (cyc < 1000 && after == 0) begin
         pe_valid = (pidx < pat_len) ? pat[pidx] : 1'b1;
         #1;
         if (seen_done) begin
            busy_after = 32'(busy);
            after = 1;
         end else begin
            if (p_init) begin
               n_init++;
               if (first_init < 0) first_init = cyc;
            end
            if (pe_ready && !prev_ready) begin
               q_odd.push_back(int'(odd_cnt));
               q_pass.push_back(int'(pass_idx));
            end
            if (pe_ready && first_ready < 0) first_ready = cyc;
            if (p_valid_data) begin
               n_valid++;
               last_beat = cyc;
               if (!pe_valid || !pe_ready) n_bad++;
            end
            if (busy && !pe_ready && !p_init && !p_write_zero && !done) begin
               n_idle++;
               if (first_idle < 0) first_idle = cyc;
            end
            if (p_write_zero) begin
               n_wz++;
               if (!odd_cnt) wz_odd0++;
            end
            if (cfg_err) n_err++;
            if (done) begin
               n_done++;
               done_cyc = cyc;
               seen_done = 1'b1;
            end
            prev_ready = pe_ready;
            if (pe_ready) pidx++;
         end
         @(negedge clk);
         cyc++;
      end
      pe_valid = 1'b0;
      checkOutput("tile_timeout", 32'(after), 1);
   endtask

   initial begin
      ill_rl[0] = 8'd0;  ill_np[0] = 8'd1;
      ill_rl[1] = 8'd47; ill_np[1] = 8'd1;
      ill_rl[2] = 8'd5;  ill_np[2] = 8'd0;

      #2;
      checkOutput("reset_outputs",
                  32'({pe_ready, p_init, p_valid_data, p_write_zero, odd_cnt, busy, done, cfg_err, pass_idx}), 0);
      @(negedge clk);
      rst = 1'b0;

      // Basic run: row 4, one pass, pe_valid always high.
      applyStimulus(8'd4, 8'd1, 16'h0000, 0);
      checkOutput("basic_n_init", n_init, 4);
      checkOutput("basic_first_init", first_init, 1);
      checkOutput("basic_first_ready", first_ready, 5);
      checkOutput("basic_n_valid", n_valid, 4);
      checkOutput("basic_last_beat", last_beat, 8);
      checkOutput("basic_first_idle", first_idle, 9);
      checkOutput("basic_n_idle", n_idle, 3);
      checkOutput("basic_n_wz", n_wz, 4);
      checkOutput("basic_wz_odd0", wz_odd0, 4);
      checkOutput("basic_done_cyc", done_cyc, 16);
      checkOutput("basic_n_done", n_done, 1);
      checkOutput("basic_busy_after", busy_after, 0);
      checkOutput("basic_n_err", n_err, 0);
      checkOutput("basic_odd", (q_odd.size() == 1) ? q_odd[0] : -1, 0);

      // Multi-pass: full-depth rows, three passes.
      applyStimulus(8'd46, 8'd3, 16'h0000, 0);
      checkOutput("mp_n_init", n_init, 46);
      checkOutput("mp_first_ready", first_ready, 47);
      checkOutput("mp_n_valid", n_valid, 138);
      checkOutput("mp_n_idle", n_idle, 9);
      checkOutput("mp_n_wz", n_wz, 46);
      checkOutput("mp_wz_odd0", wz_odd0, 46);
      checkOutput("mp_done_cyc", done_cyc, 240);
      checkOutput("mp_n_passes", q_odd.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < q_odd.size()) begin
            checkOutput("mp_odd_seq", q_odd[i], (i == 1) ? 1 : 0);
            checkOutput("mp_pass_seq", q_pass[i], i);
         end
      end

      // Stall: pe_valid pattern 1,0,0,1,1,0,1,1 during streaming.
      applyStimulus(8'd5, 8'd1, 16'h00D9, 8);
      checkOutput("stall_n_valid", n_valid, 5);
      checkOutput("stall_n_bad", n_bad, 0);
      checkOutput("stall_first_ready", first_ready, 6);
      checkOutput("stall_last_beat", last_beat, 13);
      checkOutput("stall_first_idle", first_idle, 14);
      checkOutput("stall_done_cyc", done_cyc, 22);

      // Illegal configurations.
      pe_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start = 1'b1; cfg_row_len = ill_rl[i]; cfg_num_pass = ill_np[i];
         #1;
         checkOutput("ill_err_pre", 32'(cfg_err), 0);
         @(negedge clk);
         start = 1'b0;
         #1;
         checkOutput("ill_err_pulse", 32'(cfg_err), 1);
         checkOutput("ill_busy", 32'(busy), 0);
         checkOutput("ill_strobes", 32'({p_init, pe_ready, p_valid_data, p_write_zero}), 0);
         @(negedge clk);
         #1;
         checkOutput("ill_err_clear", 32'(cfg_err), 0);
         checkOutput("ill_busy_after", 32'(busy), 0);
      end
      pe_valid = 1'b0;

      // Abort during pass 1 of a 3-pass tile, then restart.
      @(negedge clk);
      start = 1'b1; cfg_row_len = 8'd4; cfg_num_pass = 8'd3; pe_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      #1;
      checkOutput("abort_pre_pass", 32'(pass_idx), 1);
      checkOutput("abort_pre_odd", 32'(odd_cnt), 1);
      checkOutput("abort_pre_ready", 32'(pe_ready), 1);
      abort = 1'b1;
      #1;
      checkOutput("abort_strobes", 32'({p_init, pe_ready, p_valid_data, p_write_zero}), 0);
      @(negedge clk);
      abort = 1'b0;
      #1;
      checkOutput("abort_busy", 32'(busy), 0);
      checkOutput("abort_pass", 32'(pass_idx), 0);
      checkOutput("abort_odd", 32'(odd_cnt), 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         checkOutput("abort_reinit", 32'(p_init), 1);
         @(negedge clk);
         #1;
      end
      checkOutput("abort_reinit_end", 32'(p_init), 0);
      checkOutput("abort_restream", 32'(pe_ready), 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      checkOutput("abort2_busy", 32'(busy), 0);

      // Asynchronous reset in the middle of DRAIN.
      @(negedge clk);
      start = 1'b1; cfg_row_len = 8'd4; cfg_num_pass = 8'd2; pe_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      #1;
      checkOutput("rst_pre_wz", 32'(p_write_zero), 1);
      checkOutput("rst_pre_odd", 32'(odd_cnt), 1);
      checkOutput("rst_pre_pass", 32'(pass_idx), 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst",
                  32'({pe_ready, p_init, p_valid_data, p_write_zero, odd_cnt, busy, done, cfg_err, pass_idx}), 0);
      @(negedge clk);
      rst = 1'b0;
      pe_valid = 1'b0;
      #1;
      checkOutput("rst_busy_after", 32'(busy), 0);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
